gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised general-purpose I/O peripheral for the memory-mapped register region. It provides NUM_CH channels with per-bit output value and output-enable, synchronised inputs, atomic set/clear writes, and rising/falling edge interrupt capture with a single level interrupt output to the CPU. The top level decodes the region base into `sel`, drives word offsets on `addr`, muxes `rdata` into the CPU read path, and builds the tri-state pads from `gpio_out`/`gpio_oe`.

## Interface
- NUM_CH, 8, number of channels (1..32); register bits [31:NUM_CH] read 0, writes ignored
- SYNC_STAGES, 2, input synchroniser depth (≥2)

- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- sel  input  1  block selected (region decode from top)
- addr  input  3  word offset within block
- re  input  1  read strobe
- we  input  4  byte write enables; a write happens only when all four are set
- wdata  input  32  write data
- rdata  output  32  read data, registered
- gpio_in  input  NUM_CH  raw pad inputs (asynchronous)
- gpio_out  output  NUM_CH  output values
- gpio_oe  output  NUM_CH  1 = drive pad, 0 = high impedance
- irq  output  1  OR of all pending bits

## Operation
- Register map (word offset: access, meaning):
  - 0 IN: RO, synchronised inputs
  - 1 OUT: RW, output values
  - 2 OE: RW, output enables
  - 3 SET: WO, OUT |= wdata; reads 0
  - 4 CLR: WO, OUT &= ~wdata; reads 0
  - 5 RISE_EN: RW, rising-edge capture enable
  - 6 FALL_EN: RW, falling-edge capture enable
  - 7 PEND: R/W1C, captured edges; writing 1 clears the bit, writing 0 leaves it unchanged
- Write condition: sel & (we == 4'b1111). Partial-byte writes are ignored entirely.
- `gpio_out` = OUT and `gpio_oe` = OE, driven directly from the registers.
- Input path: a SYNC_STAGES flip-flop chain per bit feeds IN. A prev register holds IN from the previous cycle.
  - rise = IN & ~prev
  - fall = ~IN & prev
- Pending update each cycle: PEND_next = (PEND & ~w1c_mask) | (rise & RISE_EN) | (fall & FALL_EN).
  - A new edge in the same cycle as a W1C of that bit leaves the bit set (set wins).
- irq = |PEND, taken from the registered PEND.
- Reset values are 0 for every register, every synchroniser stage, prev, rdata and irq. All outputs are therefore high-Z, and no capture occurs until software enables it.

## Timing
- Read: with sel & re in cycle N, rdata holds the addressed register value at the edge ending cycle N, valid during cycle N+1. rdata holds its value while no read occurs.
- Write: a register updates at the edge ending the write cycle. A read of the same offset in the following cycle returns the new value.
- Pin to IN: a pad change is visible in IN exactly SYNC_STAGES edges later.
- Pin to PEND/irq: SYNC_STAGES+1 edges after the pad change.
- Edges shorter than one clock may be missed; this is accepted.
- Reset asserted mid-operation immediately clears all state, including pending interrupts, and deasserts irq.
- Writes with sel=0, and re/we while sel=0, have no effect.

## Test plan
- Reset state: hold reset low and drive gpio_in = 0xFF -> gpio_oe = 0, gpio_out = 0, irq = 0. Release reset; read offset 0 -> rdata = 0x000000FF.
- Output path: write OE = 0xF0, OUT = 0xA5, then SET 0x0A, then CLR 0x81 -> gpio_out sequence 0xA5, 0xAF, 0x2E; gpio_oe = 0xF0. Reads of offsets 3 and 4 return 0.
- Partial write: write 0xFF to OUT with we = 4'b0011 -> OUT unchanged. Write 0x1FF with full we -> OUT reads 0xFF for NUM_CH = 8.
- Edge capture: RISE_EN = 0x01, FALL_EN = 0x02; raise bit 0, then raise and lower bit 1 -> PEND = 0x01 at 3 edges after the bit-0 rise. After bit 1 falls, PEND = 0x03. irq = 1 throughout.
- W1C and collision: write PEND = 0x01 -> PEND = 0x02, irq stays 1. Write PEND = 0x02 in the same cycle a captured bit-1 falling edge arrives -> PEND = 0x02.
- Async reset mid-run: with PEND = 0x03 and OE = 0xFF, pulse reset low for half a cycle -> irq = 0, gpio_oe = 0 immediately, all registers read 0 after release.

Source files
------------

// File: rtl/gpio_bank.sv
// gpio_bank: NUM_CH-bit GPIO with set/clear writes,
// synchronised inputs and edge-capture interrupt.
module gpio_bank #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [2:0]        addr,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [NUM_CH-1:0] gpio_in,
  output logic [NUM_CH-1:0] gpio_out,
  output logic [NUM_CH-1:0] gpio_oe,
  output logic              irq
);

  typedef logic [NUM_CH-1:0] ch_t;

  localparam logic [2:0] A_IN   = 3'd0;
  localparam logic [2:0] A_OUT  = 3'd1;
  localparam logic [2:0] A_OE   = 3'd2;
  localparam logic [2:0] A_SET  = 3'd3;
  localparam logic [2:0] A_CLR  = 3'd4;
  localparam logic [2:0] A_RISE = 3'd5;
  localparam logic [2:0] A_FALL = 3'd6;
  localparam logic [2:0] A_PEND = 3'd7;

  ch_t sync_q [SYNC_STAGES];
  ch_t sync_d [SYNC_STAGES];
  ch_t prev_q, prev_d;
  ch_t out_q, out_d;
  ch_t oe_q, oe_d;
  ch_t rise_en_q, rise_en_d;
  ch_t fall_en_q, fall_en_d;
  ch_t pend_q, pend_d;
  logic [31:0] rdata_q, rdata_d;

  logic wr_en;
  logic rd_en;
  ch_t  wd;
  ch_t  in_s;
  ch_t  rise;
  ch_t  fall;
  ch_t  w1c;
  logic unused_wdata;

  assign wr_en = sel & (&we);
  assign rd_en = sel & re;
  assign wd    = wdata[NUM_CH-1:0];
  assign in_s  = sync_q[SYNC_STAGES-1];
  assign rise  = in_s & ~prev_q;
  assign fall  = ~in_s & prev_q;
  assign unused_wdata = ^wdata;

  // Synchroniser shift and edge-detect history.
  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = in_s;
  end

  // Register writes; a new edge beats a same-cycle W1C.
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr_en) begin
      case (addr)
        A_OUT:   out_d     = wd;
        A_OE:    oe_d      = wd;
        A_SET:   out_d     = out_q | wd;
        A_CLR:   out_d     = out_q & ~wd;
        A_RISE:  rise_en_d = wd;
        A_FALL:  fall_en_d = wd;
        A_PEND:  w1c       = wd;
        default: ;
      endcase
    end
    pend_d = (pend_q & ~w1c)
           | (rise & rise_en_q)
           | (fall & fall_en_q);
  end

  // Registered read mux; holds value when idle.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (addr)
        A_IN:    rdata_d[NUM_CH-1:0] = in_s;
        A_OUT:   rdata_d[NUM_CH-1:0] = out_q;
        A_OE:    rdata_d[NUM_CH-1:0] = oe_q;
        A_RISE:  rdata_d[NUM_CH-1:0] = rise_en_q;
        A_FALL:  rdata_d[NUM_CH-1:0] = fall_en_q;
        A_PEND:  rdata_d[NUM_CH-1:0] = pend_q;
        default: rdata_d = '0;
      endcase
    end
  end

  // State registers, all cleared by async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q    <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      rdata_q   <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q    <= prev_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata    = rdata_q;
  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;
  assign irq      = |pend_q;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed checks of gpio_bank
// register map, edge capture and reset.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [2:0]  addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] rv;

  gpio_bank #(.NUM_CH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr),
    .re(re), .we(we), .wdata(wdata), .rdata(rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [31:0] d,
                    input logic [3:0] w);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; we = w;
    @(posedge clk); #1;
    sel = 1'b0; we = 4'b0; wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a,
                    output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; addr = a; re = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; re = 1'b0;
    d = rdata;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; addr = '0; re = 1'b0;
    we = '0; wdata = '0; gpio_in = 8'hFF;

    // reset state
    cyc(3);
    chk("rst_oe", {24'h0, gpio_oe}, 32'h0);
    chk("rst_out", {24'h0, gpio_out}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk); reset = 1'b1;
    cyc(4);
    rd(3'd0, rv); chk("in_ff", rv, 32'h0000_00FF);

    // output path
    wr(3'd2, 32'hF0, 4'hF);
    wr(3'd1, 32'hA5, 4'hF);
    chk("out_a5", {24'h0, gpio_out}, 32'hA5);
    wr(3'd3, 32'h0A, 4'hF);
    chk("out_set", {24'h0, gpio_out}, 32'hAF);
    wr(3'd4, 32'h81, 4'hF);
    chk("out_clr", {24'h0, gpio_out}, 32'h2E);
    chk("oe_f0", {24'h0, gpio_oe}, 32'hF0);
    rd(3'd3, rv); chk("rd_set0", rv, 32'h0);
    rd(3'd4, rv); chk("rd_clr0", rv, 32'h0);
    rd(3'd1, rv); chk("rd_out", rv, 32'h2E);

    // partial and oversized writes
    wr(3'd1, 32'hFF, 4'b0011);
    rd(3'd1, rv); chk("partial", rv, 32'h2E);
    wr(3'd1, 32'h1FF, 4'hF);
    rd(3'd1, rv); chk("wide_wr", rv, 32'hFF);
    rd(3'd2, rv); chk("rd_oe", rv, 32'hF0);
    @(negedge clk); sel = 1'b0; we = 4'hF; addr = 3'd1;
    wdata = 32'h0;
    @(posedge clk); #1; we = 4'h0;
    chk("nosel_wr", {24'h0, gpio_out}, 32'hFF);

    // edge capture
    @(negedge clk); gpio_in = 8'h00;
    cyc(4);
    wr(3'd5, 32'h01, 4'hF);
    wr(3'd6, 32'h02, 4'hF);
    rd(3'd5, rv); chk("rise_en", rv, 32'h01);
    rd(3'd7, rv); chk("pend0", rv, 32'h0);
    @(negedge clk); gpio_in = 8'h01;
    cyc(2);
    chk("irq_early", {31'h0, irq}, 32'h0);
    cyc(1);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    rd(3'd7, rv); chk("pend_01", rv, 32'h01);
    @(negedge clk); gpio_in = 8'h03;
    cyc(4);
    rd(3'd7, rv); chk("pend_r1", rv, 32'h01);
    @(negedge clk); gpio_in = 8'h01;
    cyc(3);
    chk("irq_fall", {31'h0, irq}, 32'h1);
    rd(3'd7, rv); chk("pend_03", rv, 32'h03);

    // W1C and collision
    wr(3'd7, 32'h01, 4'hF);
    rd(3'd7, rv); chk("w1c_02", rv, 32'h02);
    chk("irq_w1c", {31'h0, irq}, 32'h1);
    wr(3'd7, 32'h02, 4'hF);
    rd(3'd7, rv); chk("w1c_00", rv, 32'h0);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    @(negedge clk); gpio_in = 8'h03;
    cyc(4);
    @(negedge clk); gpio_in = 8'h01;
    @(posedge clk); @(posedge clk);
    wr(3'd7, 32'h02, 4'hF);
    rd(3'd7, rv); chk("collide", rv, 32'h02);

    // async reset mid-run
    @(negedge clk); gpio_in = 8'h00;
    cyc(4);
    @(negedge clk); gpio_in = 8'h01;
    cyc(4);
    wr(3'd2, 32'hFF, 4'hF);
    rd(3'd7, rv); chk("pre_pend", rv, 32'h03);
    chk("pre_oe", {24'h0, gpio_oe}, 32'hFF);
    @(posedge clk); #2;
    reset = 1'b0; gpio_in = 8'h00;
    #1;
    chk("ar_irq", {31'h0, irq}, 32'h0);
    chk("ar_oe", {24'h0, gpio_oe}, 32'h0);
    chk("ar_rdata", rdata, 32'h0);
    #4; reset = 1'b1;
    cyc(4);
    for (int i = 0; i < 8; i++) begin
      rd(i[2:0], rv);
      chk($sformatf("ar_reg%0d", i), rv, 32'h0);
    end
    chk("ar_out", {24'h0, gpio_out}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
